// File: rtl/fig42_sweep_checker.sv
// fig42_sweep_checker: sweeps all 16 ABCD vectors, compares F1/F2 against the golden model.
// Optional build macro FIG42_CHECKER_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module fig42_sweep_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] vec,
    input  logic       f1_in,
    input  logic       f2_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail_vec
);
    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, FIN} state_t;

    state_t     state;
    logic [3:0] settle;
    logic       exp_f1;
    logic       exp_f2;
    logic       miss;
    logic       stop;

    assign exp_f1 = (vec[3] & vec[2] & vec[1]) | (~vec[3] & vec[0]);
    assign exp_f2 = (vec[3] & vec[2] & vec[1]) | (~vec[3] & ~vec[0]);
    assign miss   = {f1_in, f2_in} != {exp_f1, exp_f2};
`ifdef FIG42_CHECKER_STOP_ON_FAIL_EN
    assign stop   = miss || vec == 4'd15;
`else
    assign stop   = vec == 4'd15;
`endif

    // Sweep FSM: apply a vector, let it settle, sample and score it, then advance or finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            vec            <= 4'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 5'd0;
            first_fail_vec <= 4'd0;
            settle         <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state          <= APPLY;
                    vec            <= 4'd0;
                    busy           <= 1'b1;
                    pass           <= 1'b0;
                    err_count      <= 5'd0;
                    first_fail_vec <= 4'd0;
                    settle         <= 4'd0;
                end
                APPLY: begin
                    settle <= settle + 4'd1;
                    if (settle == 4'(SETTLE_CYCLES - 1)) state <= SAMPLE;
                end
                SAMPLE: begin
                    settle <= 4'd0;
                    if (miss && err_count != 5'd16) err_count <= err_count + 5'd1;
                    if (miss && err_count == 5'd0) first_fail_vec <= vec;
                    if (stop) begin
                        state <= FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= !miss && err_count == 5'd0;
                    end else begin
                        state <= APPLY;
                        vec   <= vec + 4'd1;
                    end
                end
                FIN: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fig42_sweep_checker.sv
// tb_fig42_sweep_checker: table-driven and randomized sweeps against a truth-table reference model.
module tb_fig42_sweep_checker;
    localparam int S = 2;
    localparam logic [15:0] G1 = 16'hC0AA;
    localparam logic [15:0] G2 = 16'hC055;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  vec;
    logic        f1_in, f2_in, busy, done, pass;
    logic [4:0]  err_count;
    logic [3:0]  first_fail_vec;
    logic [15:0] r1 = G1;
    logic [15:0] r2 = G2;
    int checks = 0;
    int passed = 0;

    assign f1_in = r1[vec];
    assign f2_in = r2[vec];

    fig42_sweep_checker #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec(vec),
        .f1_in(f1_in), .f2_in(f2_in), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .first_fail_vec(first_fail_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: walk the truth tables, score each vector, note how far the sweep runs.
    task automatic model(input logic [15:0] a, input logic [15:0] b,
                         output int errs, output int first, output int ps,
                         output int nvec, output int lastv);
        errs = 0; first = 0; nvec = 0; lastv = 15;
        for (int v = 0; v < 16; v++) begin
            nvec++;
            if (a[v] != G1[v] || b[v] != G2[v]) begin
                if (errs == 0) first = v;
                errs++;
`ifdef FIG42_CHECKER_STOP_ON_FAIL_EN
                lastv = v;
                break;
`endif
            end
        end
        ps = (errs == 0) ? 1 : 0;
    endtask

    task automatic sweep(input string tag, input bit repulse);
        int errs, first, ps, nv, lv, k, nd;
        bit rp;
        rp = repulse;
        model(r1, r2, errs, first, ps, nv, lv);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk({tag, " busy"}, int'(busy), 1);
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
            if (rp && busy && vec == 4'd4) begin start = 1'b1; rp = 1'b0; end
            else start = 1'b0;
        end
        start = 1'b0;
        chk({tag, " cycles"}, k, nv * (S + 1));
        chk({tag, " err_count"}, int'(err_count), errs);
        chk({tag, " first_fail"}, int'(first_fail_vec), first);
        chk({tag, " pass"}, int'(pass), ps);
        chk({tag, " vec"}, int'(vec), lv);
        chk({tag, " busy_fin"}, int'(busy), 0);
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk({tag, " extra_done"}, nd, 0);
        chk({tag, " pass_hold"}, int'(pass), ps);
    endtask

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        int          errs;
        int          first;
        int          ps;
    } vec_t;

    initial begin
        vec_t tbl[3];
        int k, nd;
        tbl[0] = '{"clean", G1, G2, 0, 0, 1};
`ifdef FIG42_CHECKER_STOP_ON_FAIL_EN
        tbl[1] = '{"f1_tied0", 16'h0000, G2, 1, 1, 0};
        tbl[2] = '{"f2_inv", G1, ~G2, 1, 0, 0};
`else
        tbl[1] = '{"f1_tied0", 16'h0000, G2, 6, 1, 0};
        tbl[2] = '{"f2_inv", G1, ~G2, 16, 0, 0};
`endif
        repeat (2) @(negedge clk);
        chk("rst vec", int'(vec), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst pass", int'(pass), 0);
        chk("rst err", int'(err_count), 0);
        chk("rst ffv", int'(first_fail_vec), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            r1 = tbl[i].a;
            r2 = tbl[i].b;
            sweep(tbl[i].name, 1'b0);
            chk({tbl[i].name, " tbl_err"}, int'(err_count), tbl[i].errs);
            chk({tbl[i].name, " tbl_ffv"}, int'(first_fail_vec), tbl[i].first);
            chk({tbl[i].name, " tbl_pass"}, int'(pass), tbl[i].ps);
        end

        for (int i = 0; i < 6; i++) begin
            r1 = G1 ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            r2 = G2 ^ (16'($urandom) & 16'($urandom));
            if (i == 0) begin r1 = G1; r2 = G2; end
            sweep($sformatf("rand%0d", i), 1'b0);
        end

        r1 = G1; r2 = G2;
        sweep("repulse", 1'b1);

        r1 = 16'h0000;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = 0;
        while (vec != 4'd7 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("midrst reached_7", int'(vec), 7);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst vec", int'(vec), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst pass", int'(pass), 0);
        chk("midrst err", int'(err_count), 0);
        chk("midrst ffv", int'(first_fail_vec), 0);
        @(negedge clk) rst_n = 1'b1;
        nd = 0;
        repeat (60) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("midrst no_activity", nd, 0);
        r1 = G1;
        sweep("after_rst", 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
